id_ex_stage: RTL and testbench

- Decode/operand stage that sits directly upstream of the ALU.
- Takes a fetched RV32I instruction and reads rs1/rs2 from an internal 32x32 register file.
- Generates the immediate and the 4-bit ALU opcode.
- Registers op1/op2/alu_op and destination info into an ID/EX pipeline register that drives the ALU the following cycle.
- Accepts the writeback port from downstream.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/regfile.sv | 47 ++++
 rtl/id_ex_stage.sv | 183 ++++++++++++++++++
 tb/tb_id_ex_stage.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I decode constants for the ID/EX slice.
// ALU opcode encodings, major opcodes and funct3 values.
package riscv_pkg;

  typedef logic [3:0] alu_op_t;

  localparam alu_op_t ALUOP_AND = 4'b0000;
  localparam alu_op_t ALUOP_OR  = 4'b0001;
  localparam alu_op_t ALUOP_ADD = 4'b0010;
  localparam alu_op_t ALUOP_SUB = 4'b0110;
  localparam alu_op_t ALUOP_LT  = 4'b0111;
  localparam alu_op_t ALUOP_SRL = 4'b1000;
  localparam alu_op_t ALUOP_SLL = 4'b1001;
  localparam alu_op_t ALUOP_SRA = 4'b1010;
  localparam alu_op_t ALUOP_XOR = 4'b1101;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [2:0] FUNCT3_ADD  = 3'b000;
  localparam logic [2:0] FUNCT3_SLL  = 3'b001;
  localparam logic [2:0] FUNCT3_SLT  = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU = 3'b011;
  localparam logic [2:0] FUNCT3_XOR  = 3'b100;
  localparam logic [2:0] FUNCT3_SR   = 3'b101;
  localparam logic [2:0] FUNCT3_OR   = 3'b110;
  localparam logic [2:0] FUNCT3_AND  = 3'b111;

endpackage

// File: rtl/regfile.sv
// 2R1W register file, x0 hardwired to zero, sync reset clear.
// REGFILE_WRITE_BYPASS_EN makes same-cycle writes visible on reads.
module regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [4:0]      waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2
);

  logic [XLEN-1:0] mem_q [NUM_REGS];
  logic [XLEN-1:0] mem_d [NUM_REGS];

  always_comb begin
    mem_d = mem_q;
    if (we && waddr != '0)
      mem_d[waddr] = wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++)
        mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  always_comb begin
    rdata1 = (raddr1 == '0) ? '0 : mem_q[raddr1];
    rdata2 = (raddr2 == '0) ? '0 : mem_q[raddr2];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && waddr != '0 && waddr == raddr1)
      rdata1 = wdata;
    if (we && waddr != '0 && waddr == raddr2)
      rdata2 = wdata;
`endif
  end

endmodule

// File: rtl/id_ex_stage.sv
// RV32I decode/operand stage feeding the ALU through an ID/EX register.
// Optional REGFILE_WRITE_BYPASS_EN enables regfile write-through.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [31:0]     in_instr,
  input  logic            stall,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_op1,
  output logic [XLEN-1:0] ex_op2,
  output alu_op_t         ex_alu_op,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_illegal
);

  logic [6:0]      opcode;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] shamt;

  alu_op_t         dec_alu_op;
  logic [XLEN-1:0] dec_op2;
  logic            dec_reg_write;
  logic            dec_illegal;

  logic            valid_q, valid_d;
  logic [XLEN-1:0] op1_q, op1_d;
  logic [XLEN-1:0] op2_q, op2_d;
  alu_op_t         alu_op_q, alu_op_d;
  logic [XLEN-1:0] rs2_data_q, rs2_data_d;
  logic [4:0]      rd_q, rd_d;
  logic            reg_write_q, reg_write_d;
  logic            illegal_q, illegal_d;

  regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk    (clk),
    .rst    (rst),
    .we     (wb_we),
    .waddr  (wb_rd),
    .wdata  (wb_data),
    .raddr1 (in_instr[19:15]),
    .raddr2 (in_instr[24:20]),
    .rdata1 (rs1_data),
    .rdata2 (rs2_data)
  );

  assign opcode = in_instr[6:0];
  assign funct3 = in_instr[14:12];
  assign imm_i  = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
  assign imm_s  = {{(XLEN-12){in_instr[31]}},
                   in_instr[31:25], in_instr[11:7]};
  assign shamt  = XLEN'(in_instr[24:20]);

  // alt selects SUB/SRA; funct3 011 has no ALU mapping here
  function automatic alu_op_t f3_op(
    input logic [2:0] f3,
    input logic       alt
  );
    alu_op_t op;
    op = ALUOP_ADD;
    unique case (f3)
      FUNCT3_ADD:  op = alt ? ALUOP_SUB : ALUOP_ADD;
      FUNCT3_SLL:  op = ALUOP_SLL;
      FUNCT3_SLT:  op = ALUOP_LT;
      FUNCT3_SLTU: op = ALUOP_ADD;
      FUNCT3_XOR:  op = ALUOP_XOR;
      FUNCT3_SR:   op = alt ? ALUOP_SRA : ALUOP_SRL;
      FUNCT3_OR:   op = ALUOP_OR;
      FUNCT3_AND:  op = ALUOP_AND;
    endcase
    return op;
  endfunction

  always_comb begin
    dec_alu_op    = ALUOP_ADD;
    dec_op2       = rs2_data;
    dec_reg_write = 1'b0;
    dec_illegal   = 1'b0;
    case (opcode)
      OP_R: begin
        dec_alu_op    = f3_op(funct3, in_instr[30]);
        dec_illegal   = (funct3 == FUNCT3_SLTU);
        dec_reg_write = ~dec_illegal;
      end
      OP_IMM: begin
        dec_alu_op = f3_op(funct3,
          (funct3 == FUNCT3_SR) & in_instr[30]);
        dec_op2 = (funct3 == FUNCT3_SLL ||
                   funct3 == FUNCT3_SR) ? shamt : imm_i;
        dec_illegal   = (funct3 == FUNCT3_SLTU);
        dec_reg_write = ~dec_illegal;
      end
      OP_LOAD: begin
        dec_op2       = imm_i;
        dec_reg_write = 1'b1;
      end
      OP_STORE: begin
        dec_op2 = imm_s;
      end
      OP_BRANCH: begin
        dec_alu_op = ALUOP_SUB;
      end
      default: begin
        dec_illegal = 1'b1;
        dec_op2     = imm_i;
      end
    endcase
  end

  always_comb begin
    valid_d     = valid_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_op_d    = alu_op_q;
    rs2_data_d  = rs2_data_q;
    rd_d        = rd_q;
    reg_write_d = reg_write_q;
    illegal_d   = illegal_q;
    if (flush) begin
      valid_d     = 1'b0;
      reg_write_d = 1'b0;
    end else if (!stall) begin
      valid_d     = in_valid;
      op1_d       = rs1_data;
      op2_d       = dec_op2;
      alu_op_d    = dec_alu_op;
      rs2_data_d  = rs2_data;
      rd_d        = in_instr[11:7];
      reg_write_d = in_valid & dec_reg_write;
      illegal_d   = dec_illegal;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      op1_q       <= '0;
      op2_q       <= '0;
      alu_op_q    <= ALUOP_AND;
      rs2_data_q  <= '0;
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      valid_q     <= valid_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_op_q    <= alu_op_d;
      rs2_data_q  <= rs2_data_d;
      rd_q        <= rd_d;
      reg_write_q <= reg_write_d;
      illegal_q   <= illegal_d;
    end
  end

  assign ex_valid     = valid_q;
  assign ex_op1       = op1_q;
  assign ex_op2       = op2_q;
  assign ex_alu_op    = alu_op_q;
  assign ex_rs2_data  = rs2_data_q;
  assign ex_rd        = rd_q;
  assign ex_reg_write = reg_write_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed cases plus random
// traffic against a behavioural model of the decode and register file.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        stall;
  logic        flush;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        ex_valid;
  logic [31:0] ex_op1;
  logic [31:0] ex_op2;
  logic [3:0]  ex_alu_op;
  logic [31:0] ex_rs2_data;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        ex_illegal;

  id_ex_stage dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_instr     (in_instr),
    .stall        (stall),
    .flush        (flush),
    .wb_we        (wb_we),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .ex_valid     (ex_valid),
    .ex_op1       (ex_op1),
    .ex_op2       (ex_op2),
    .ex_alu_op    (ex_alu_op),
    .ex_rs2_data  (ex_rs2_data),
    .ex_rd        (ex_rd),
    .ex_reg_write (ex_reg_write),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        valid;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [3:0]  alu;
    logic [31:0] rs2d;
    logic [4:0]  rd;
    logic        rw;
    logic        ill;
    logic        op2dc;
  } exp_t;

  int checks = 0;
  int errors = 0;
  logic [31:0] rf [32];
  exp_t exp_cur;
  logic cmp_en = 1'b0;

`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, req, $time);
    end
  endtask

  // {illegal, alu_op} for the shared R/I funct3 table
  function automatic logic [4:0] f3_alu(input logic [2:0] f3,
                                        input logic alt);
    case (f3)
      3'd0:    return alt ? 5'b0_0110 : 5'b0_0010;
      3'd1:    return 5'b0_1001;
      3'd2:    return 5'b0_0111;
      3'd3:    return 5'b1_0010;
      3'd4:    return 5'b0_1101;
      3'd5:    return alt ? 5'b0_1010 : 5'b0_1000;
      3'd6:    return 5'b0_0001;
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic exp_t decode(input logic [31:0] i,
                                  input logic [31:0] a,
                                  input logic [31:0] b);
    exp_t e;
    logic [2:0] f3;
    logic [31:0] ii, si;
    f3 = i[14:12];
    ii = {{20{i[31]}}, i[31:20]};
    si = {{20{i[31]}}, i[31:25], i[11:7]};
    e = '0;
    e.valid = 1'b1;
    e.op1 = a;
    e.rs2d = b;
    e.rd = i[11:7];
    e.alu = 4'b0010;
    case (i[6:0])
      7'b0110011: begin
        e.op2 = b;
        e.rw = 1'b1;
        {e.ill, e.alu} = f3_alu(f3, i[30]);
      end
      7'b0010011: begin
        e.op2 = (f3 == 3'd1 || f3 == 3'd5) ? {27'b0, i[24:20]} : ii;
        e.rw = 1'b1;
        {e.ill, e.alu} = f3_alu(f3, (f3 == 3'd5) && i[30]);
      end
      7'b0000011: begin
        e.op2 = ii;
        e.rw = 1'b1;
      end
      7'b0100011: e.op2 = si;
      7'b1100011: begin
        e.op2 = b;
        e.alu = 4'b0110;
      end
      default: begin
        e.ill = 1'b1;
        e.op2dc = 1'b1;
      end
    endcase
    if (e.ill) e.rw = 1'b0;
    return e;
  endfunction

  function automatic logic [31:0] rd_model(input logic [4:0] a);
    if (a == 5'd0) return 32'h0;
    if (BYPASS && wb_we && wb_rd == a) return wb_data;
    return rf[a];
  endfunction

  // drive one cycle of inputs, advance the clock, update the model
  task automatic step(input logic v, input logic [31:0] ins,
                      input logic st, input logic fl,
                      input logic we, input logic [4:0] rd,
                      input logic [31:0] d, input logic r);
    exp_t dec, nxt;
    in_valid = v; in_instr = ins; stall = st; flush = fl;
    wb_we = we; wb_rd = rd; wb_data = d; rst = r;
    dec = decode(ins, rd_model(ins[19:15]), rd_model(ins[24:20]));
    nxt = exp_cur;
    if (r) begin
      nxt = '0;
    end else if (fl) begin
      nxt = dec;
      nxt.valid = 1'b0;
      nxt.rw = 1'b0;
    end else if (!st) begin
      nxt = dec;
      nxt.valid = v;
      nxt.rw = v & dec.rw;
    end
    @(posedge clk);
    #1;
    if (r) begin
      for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    end else if (we && rd != 5'd0) begin
      rf[rd] = d;
    end
    exp_cur = nxt;
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ex_valid", {31'b0, ex_valid}, {31'b0, exp_cur.valid});
      chk("ex_reg_write", {31'b0, ex_reg_write}, {31'b0, exp_cur.rw});
      if (exp_cur.valid) begin
        chk("ex_op1", ex_op1, exp_cur.op1);
        chk("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, exp_cur.alu});
        chk("ex_rs2_data", ex_rs2_data, exp_cur.rs2d);
        chk("ex_rd", {27'b0, ex_rd}, {27'b0, exp_cur.rd});
        chk("ex_illegal", {31'b0, ex_illegal}, {31'b0, exp_cur.ill});
        if (!exp_cur.op2dc)
          chk("ex_op2", ex_op2, exp_cur.op2);
      end
    end
  end

  localparam logic [31:0] ADD_X3 = 32'h002081B3;
  localparam logic [31:0] SRAI   = 32'h4030D213;
  localparam logic [31:0] ADD_X0 = 32'h000002B3;
  localparam logic [31:0] SW     = 32'hFE20AE23;
  localparam logic [31:0] ILL    = 32'h0000007F;

  initial begin
    logic [31:0] ins;
    logic [6:0]  opc;
    logic [4:0]  wr;
    exp_t tmp;
    exp_cur = '0;
    for (int k = 0; k < 32; k++) rf[k] = 32'h0;
    step(0, 0, 0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst_op1", ex_op1, 32'd0);
    chk("rst_op2", ex_op2, 32'd0);
    chk("rst_alu", {28'b0, ex_alu_op}, 32'd0);
    chk("rst_rs2", ex_rs2_data, 32'd0);
    chk("rst_rd", {27'b0, ex_rd}, 32'd0);
    chk("rst_rw", {31'b0, ex_reg_write}, 32'd0);
    chk("rst_ill", {31'b0, ex_illegal}, 32'd0);
    cmp_en = 1'b1;

    step(0, 0, 0, 0, 1, 5'd1, 32'h5, 0);
    step(0, 0, 0, 0, 1, 5'd2, 32'hFFFFFFFF, 0);
    step(1, ADD_X3, 0, 0, 0, 0, 0, 0);
    chk("add_op1", ex_op1, 32'h5);
    chk("add_op2", ex_op2, 32'hFFFFFFFF);
    chk("add_alu", {28'b0, ex_alu_op}, 32'h2);
    chk("add_rd", {27'b0, ex_rd}, 32'd3);
    chk("add_rw", {31'b0, ex_reg_write}, 32'd1);

    step(1, SRAI, 0, 0, 0, 0, 0, 0);
    chk("srai_alu", {28'b0, ex_alu_op}, 32'hA);
    chk("srai_op2", ex_op2, 32'd3);
    step(0, 0, 0, 0, 1, 5'd0, 32'h1234, 0);
    step(1, ADD_X0, 0, 0, 0, 0, 0, 0);
    chk("x0_read", ex_op1, 32'd0);

    step(1, SW, 0, 0, 0, 0, 0, 0);
    chk("sw_op2", ex_op2, 32'hFFFFFFFC);
    chk("sw_alu", {28'b0, ex_alu_op}, 32'h2);
    chk("sw_rs2", ex_rs2_data, 32'hFFFFFFFF);
    chk("sw_rw", {31'b0, ex_reg_write}, 32'd0);

    step(1, ADD_X3, 0, 0, 0, 0, 0, 0);
    step(1, SW, 1, 0, 0, 0, 0, 0);
    step(1, SRAI, 1, 0, 0, 0, 0, 0);
    step(1, ILL, 1, 0, 0, 0, 0, 0);
    chk("stall_op2", ex_op2, 32'hFFFFFFFF);
    chk("stall_rd", {27'b0, ex_rd}, 32'd3);
    chk("stall_valid", {31'b0, ex_valid}, 32'd1);
    step(1, ADD_X3, 1, 1, 0, 0, 0, 0);
    chk("stall_flush_valid", {31'b0, ex_valid}, 32'd0);

    step(1, ILL, 0, 0, 0, 0, 0, 0);
    chk("ill_flag", {31'b0, ex_illegal}, 32'd1);
    chk("ill_alu", {28'b0, ex_alu_op}, 32'h2);
    chk("ill_rw", {31'b0, ex_reg_write}, 32'd0);
    step(1, ADD_X3, 0, 0, 1, 5'd1, 32'h7, 0);
    chk("same_cycle_op1", ex_op1, BYPASS ? 32'h7 : 32'h5);
    step(1, ADD_X3, 0, 0, 0, 0, 0, 0);
    chk("after_write_op1", ex_op1, 32'h7);

    step(1, SRAI, 0, 0, 0, 0, 0, 0);
    step(1, ADD_X3, 0, 0, 1, 5'd1, 32'h99, 1);
    chk("midrst_valid", {31'b0, ex_valid}, 32'd0);
    chk("midrst_op1", ex_op1, 32'd0);
    chk("midrst_alu", {28'b0, ex_alu_op}, 32'd0);
    step(1, ADD_X3, 0, 0, 0, 0, 0, 0);
    chk("midrst_x1", ex_op1, 32'd0);

    // prime several registers with nonzero data
    for (int k = 1; k < 32; k++)
      step(0, 0, 0, 0, 1, 5'(k), $urandom, 0);

    // hand-checked model entries
    tmp = decode(32'h40208033, 32'd1, 32'd2);
    chk("model_sub", {28'b0, tmp.alu}, 32'h6);
    tmp = decode(32'h8000F093, 32'd0, 32'd0);
    chk("model_andi_imm", tmp.op2, 32'hFFFFF800);

    for (int n = 0; n < 3000; n++) begin
      ins = $urandom;
      case ($urandom_range(0, 5))
        0: opc = 7'b0110011;
        1: opc = 7'b0010011;
        2: opc = 7'b0000011;
        3: opc = 7'b0100011;
        4: opc = 7'b1100011;
        default: opc = 7'($urandom);
      endcase
      ins[6:0] = opc;
      wr = ($urandom_range(0, 1) == 0) ? ins[19:15] : 5'($urandom);
      step($urandom_range(0, 3) != 0, ins,
           $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           $urandom_range(0, 1) == 0, wr, $urandom,
           $urandom_range(0, 49) == 0);
    end

    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
